// File: rtl/des_inv_if.sv
// Data-path bundle for des_inv: direction flag, 64-bit block, sixteen 48-bit
// round subkeys (encrypt order) and the registered result.
interface des_inv_if;
  logic        flag;
  logic [0:63] des_in;
  logic [0:47] k1, k2, k3, k4, k5, k6, k7, k8;
  logic [0:47] k9, k10, k11, k12, k13, k14, k15, k16;
  logic [0:63] des_out;

  modport master (
    output flag, des_in,
    output k1, k2, k3, k4, k5, k6, k7, k8,
    output k9, k10, k11, k12, k13, k14, k15, k16,
    input  des_out
  );

  modport slave (
    input  flag, des_in,
    input  k1, k2, k3, k4, k5, k6, k7, k8,
    input  k9, k10, k11, k12, k13, k14, k15, k16,
    output des_out
  );
endinterface

// File: rtl/des_inv.sv
// Fully unrolled single-cycle DES encrypt/decrypt core with a registered output.
// Define DES_INV_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module des_inv (
  input  logic       clk,
  input  logic       rst,
  des_inv_if.slave   bus
);

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each row is one S-box flattened as row*16 + column.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [0:63] permute_ip(input logic [0:63] d);
    for (int i = 0; i < 64; i++) permute_ip[i] = d[6'(IP_TAB[i] - 1)];
  endfunction

  function automatic logic [0:63] permute_fp(input logic [0:63] d);
    for (int i = 0; i < 64; i++) permute_fp[i] = d[6'(FP_TAB[i] - 1)];
  endfunction

  function automatic logic [0:31] feistel(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:31] s;
    logic [5:0]  g;
    for (int i = 0; i < 48; i++) x[i] = r[5'(E_TAB[i] - 1)] ^ k[i];
    for (int b = 0; b < 8; b++) begin
      g = x[b*6 +: 6];
      s[b*4 +: 4] = 4'(SBOX[b][{g[5], g[0], g[4:1]}]);
    end
    for (int i = 0; i < 32; i++) feistel[i] = s[5'(P_TAB[i] - 1)];
  endfunction

  logic [0:47] key_in  [16];
  logic [0:47] cur_key [16];
  logic [0:63] cur_data;
  logic        cur_flag;
  logic [0:63] result;

  always_comb begin
    key_in[0]  = bus.k1;  key_in[1]  = bus.k2;  key_in[2]  = bus.k3;  key_in[3]  = bus.k4;
    key_in[4]  = bus.k5;  key_in[5]  = bus.k6;  key_in[6]  = bus.k7;  key_in[7]  = bus.k8;
    key_in[8]  = bus.k9;  key_in[9]  = bus.k10; key_in[10] = bus.k11; key_in[11] = bus.k12;
    key_in[12] = bus.k13; key_in[13] = bus.k14; key_in[14] = bus.k15; key_in[15] = bus.k16;
  end

`ifdef DES_INV_IN_REG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_flag <= 1'b0;
      cur_data <= '0;
      for (int i = 0; i < 16; i++) cur_key[i] <= '0;
    end else begin
      cur_flag <= bus.flag;
      cur_data <= bus.des_in;
      cur_key  <= key_in;
    end
  end
`else
  always_comb begin
    cur_flag = bus.flag;
    cur_data = bus.des_in;
    cur_key  = key_in;
  end
`endif

  // Decryption is the same network walked with the subkey list reversed.
  always_comb begin
    logic [0:63] lr;
    logic [0:31] l, r, t;
    logic [0:47] rk;
    lr = permute_ip(cur_data);
    l  = lr[0:31];
    r  = lr[32:63];
    for (int i = 0; i < 16; i++) begin
      rk = cur_flag ? cur_key[i] : cur_key[15 - i];
      t  = r;
      r  = l ^ feistel(r, rk);
      l  = t;
    end
    result = permute_fp({r, l});
  end

  always_ff @(posedge clk) begin
    if (!rst) bus.des_out <= '0;
    else      bus.des_out <= result;
  end

endmodule

// File: tb/tb_des_inv.sv
// Scoreboard testbench for des_inv: known DES vectors, back-to-back direction
// switching, mid-stream reset and randomized round trips against a DES model.
module tb_des_inv;

`ifdef DES_INV_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [15:0][47:0] sk_t;

  typedef struct {
    logic [63:0] value;
    int          due;
    string       name;
  } exp_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  des_inv_if bus ();

  des_inv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model on MSB-first packed words: DES bit b of a w-bit word is word[w-b].
  function automatic sk_t key_schedule(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    sk_t sk;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[r][47 - i] = cd[56 - PC2_T[i]];
    end
    return sk;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, p;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) x[47 - i] = r[32 - E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47 - 6*b -: 6];
      s[31 - 4*b -: 4] = 4'(SB[b][(2*int'(six[5]) + int'(six[0])) * 16 + int'(six[4:1])]);
    end
    for (int i = 0; i < 32; i++) p[31 - i] = s[32 - P_T[i]];
    return p;
  endfunction

  // The final permutation is obtained by inverting IP rather than from its own table.
  function automatic logic [63:0] des_ref(input logic [63:0] data, input sk_t sk, input logic enc);
    logic [63:0] t, pre, res;
    logic [31:0] l, r, nl;
    for (int i = 0; i < 64; i++) t[63 - i] = data[64 - IP_T[i]];
    l = t[63:32];
    r = t[31:0];
    for (int n = 0; n < 16; n++) begin
      nl = r;
      r  = l ^ f_ref(r, enc ? sk[n] : sk[15 - n]);
      l  = nl;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[64 - IP_T[i]] = pre[63 - i];
    return res;
  endfunction

  task automatic apply_stimulus(input logic f, input logic [63:0] data, input sk_t sk,
                                input logic [63:0] expect_val, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.flag = f;
    bus.des_in = data;
    bus.k1  = sk[0];  bus.k2  = sk[1];  bus.k3  = sk[2];  bus.k4  = sk[3];
    bus.k5  = sk[4];  bus.k6  = sk[5];  bus.k7  = sk[6];  bus.k8  = sk[7];
    bus.k9  = sk[8];  bus.k10 = sk[9];  bus.k11 = sk[10]; bus.k12 = sk[11];
    bus.k13 = sk[12]; bus.k14 = sk[13]; bus.k15 = sk[14]; bus.k16 = sk[15];
    e.value = expect_val;
    e.due = cyc + LAT;
    e.name = name;
    sb.push_back(e);
  endtask

  // A reset cycle throws away anything still in flight and forces zero on the next edge.
  task automatic apply_reset_cycle(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    while (sb.size() > 0 && sb[sb.size() - 1].due > cyc) void'(sb.pop_back());
    e.value = 64'h0;
    e.due = cyc + 1;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    n_checks++;
    if (e.due != cyc || bus.des_out !== e.value) begin
      n_fail++;
      $display("[TB] FAIL %s: des_out=%h expected %h (cycle %0d, due %0d)",
               e.name, bus.des_out, e.value, cyc, e.due);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) check_output(sb.pop_front());
    end
  end

  initial begin : stimulus
    sk_t         sk_a, sk_b, sk_r;
    logic [63:0] key, x, y, c;
    bus.flag = 1'b0;
    bus.des_in = '0;
    bus.k1 = '0; bus.k2 = '0; bus.k3 = '0; bus.k4 = '0; bus.k5 = '0; bus.k6 = '0;
    bus.k7 = '0; bus.k8 = '0; bus.k9 = '0; bus.k10 = '0; bus.k11 = '0; bus.k12 = '0;
    bus.k13 = '0; bus.k14 = '0; bus.k15 = '0; bus.k16 = '0;

    apply_reset_cycle("reset_init0");
    apply_reset_cycle("reset_init1");

    sk_a = key_schedule(64'h133457799BBCDFF1);
    sk_b = key_schedule(64'h0E329232EA6D0D73);
    $display("[TB] known-answer vectors");
    apply_stimulus(1'b1, 64'h0123456789ABCDEF, sk_a, 64'h85E813540F0AB405, "enc_vec");
    apply_stimulus(1'b0, 64'h85E813540F0AB405, sk_a, 64'h0123456789ABCDEF, "dec_vec");
    apply_stimulus(1'b1, 64'h8787878787878787, sk_b, 64'h0000000000000000, "enc_vec2");

    $display("[TB] back-to-back direction switching");
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        apply_stimulus(1'b1, 64'h0123456789ABCDEF, sk_a, 64'h85E813540F0AB405, "b2b_enc");
      else
        apply_stimulus(1'b0, 64'h85E813540F0AB405, sk_a, 64'h0123456789ABCDEF, "b2b_dec");
    end

    $display("[TB] reset mid-stream");
    apply_stimulus(1'b1, 64'h0123456789ABCDEF, sk_a, 64'h85E813540F0AB405, "pre_rst_enc");
    apply_stimulus(1'b0, 64'h85E813540F0AB405, sk_a, 64'h0123456789ABCDEF, "pre_rst_dec");
    apply_reset_cycle("reset_mid");
    apply_stimulus(1'b1, 64'h8787878787878787, sk_b, 64'h0000000000000000, "post_rst_enc");
    apply_stimulus(1'b0, 64'h85E813540F0AB405, sk_a, 64'h0123456789ABCDEF, "post_rst_dec");

    $display("[TB] randomized round trips");
    for (int n = 0; n < 1000; n++) begin
      key  = {$urandom, $urandom};
      x    = {$urandom, $urandom};
      y    = {$urandom, $urandom};
      sk_r = key_schedule(key);
      c    = des_ref(x, sk_r, 1'b1);
      apply_stimulus(1'b1, x, sk_r, c, "rand_enc");
      apply_stimulus(1'b0, c, sk_r, x, "rand_roundtrip");
      apply_stimulus(1'b0, y, sk_r, des_ref(y, sk_r, 1'b0), "rand_dec");
    end

    for (int i = 0; i < LAT + 4 && sb.size() > 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: no output observed, expected %h", e.name, e.value);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
